// File: rtl/dsp_mac_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_pkg
// Shared types and constants for the DSP48A1 MAC sequencer.
//   state_t   : sequencer FSM states
//   beat_t    : per-beat control flags carried alongside the slice pipeline
//   OPM_FIRST : OPMODE for tap 0 (X=M, Z=0, add, CIN=0)
//   OPM_ACC   : OPMODE for later taps (X=M, Z=P, add, CIN=0)
//   MAC_LAT   : edges from acceptance until the product is in P
// -----------------------------------------------------------------------------
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam int         MAC_LAT   = 3;

endpackage

// File: rtl/dsp_mac_vpipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_vpipe
// MAC_LAT-deep shift register of {valid, first, last} beat flags that tracks
// each accepted pair through the slice's A1/B1 -> M/OPMODE -> P registers.
// Index 0 of each output vector is stage 1 (one edge after acceptance).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous active-high clear of every stage
//   in_valid/first/last  : flags of the beat accepted this cycle
//   valid_q/first_q/last_q : per-stage flags, [0]=stage 1 .. [MAC_LAT-1]
// -----------------------------------------------------------------------------
import dsp_mac_pkg::*;

module dsp_mac_vpipe (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  output logic [MAC_LAT-1:0] valid_q,
  output logic [MAC_LAT-1:0] first_q,
  output logic [MAC_LAT-1:0] last_q
);

  beat_t                  in_beat;
  beat_t [MAC_LAT-1:0]    pipe_q;

  assign in_beat = '{valid: in_valid, first: in_first, last: in_last};

  // NOTE: every stage is reset, unlike a plain data store, because a stale
  // flag here would fire slice clock enables or a bogus result capture.
  // NOTE: sequential state uses non-blocking assignments so all stages shift
  // on the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else if (clr) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[MAC_LAT-2:0], in_beat};
    end
  end

  always_comb begin
    for (int i = 0; i < MAC_LAT; i++) begin
      valid_q[i] = pipe_q[i].valid;
      first_q[i] = pipe_q[i].first;
      last_q[i]  = pipe_q[i].last;
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Drives a DSP48A1 slice (A1/B1, M, OPMODE and P registered) so N_TAPS
// unsigned 18x18 products accumulate in P, then captures P into m_data.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   s_valid/s_ready/s_sample/s_coef : input pair handshake
//   m_valid/m_ready/m_data       : result handshake (48-bit sum)
//   busy                         : FSM not in IDLE
//   dsp_a/dsp_b/dsp_opmode       : slice operands and OPMODE
//   dsp_cea/ceb/ceop/cem/cep     : slice clock enables
//   dsp_rst                      : active-high reset to all slice rst* ports
//   dsp_p                        : slice P output
// Optional build macro MAC_SEQ_PERF_EN adds perf_stall (RUN cycles with
// s_valid low) and perf_jobs (results captured), both 32-bit wrapping.
// -----------------------------------------------------------------------------
import dsp_mac_pkg::*;

module dsp_mac_sequencer #(
  parameter int N_TAPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_sample,
  input  logic [17:0] s_coef,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_data,
  output logic        busy,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_cea,
  output logic        dsp_ceb,
  output logic        dsp_ceop,
  output logic        dsp_cem,
  output logic        dsp_cep,
  output logic        dsp_rst,
`ifdef MAC_SEQ_PERF_EN
  output logic [31:0] perf_stall,
  output logic [31:0] perf_jobs,
`endif
  input  logic [47:0] dsp_p
);

  localparam int               TAP_W    = $clog2(N_TAPS) + 1;
  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(N_TAPS - 1);

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic               acc;
  logic               beat_first, beat_last;
  logic               rst_hold_q;
  logic [MAC_LAT-1:0] v_q, f_q, l_q;
  logic               res_cap;

  // Held high through the first edge after rst_n releases so the slice's
  // synchronous resets see at least one active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_hold_q <= 1'b1;
    else        rst_hold_q <= 1'b0;
  end

  assign dsp_rst = rst_hold_q;

  // No beat is taken while the slice is still held in reset, otherwise it
  // would be dropped by the cleared A1/B1 registers.
  assign s_ready = (state_q == RUN) ||
                   ((state_q == IDLE) && (!m_valid || m_ready) && !dsp_rst);
  assign acc     = s_valid && s_ready;
  assign busy    = (state_q != IDLE);
  assign res_cap = l_q[MAC_LAT-1];

  assign dsp_a      = s_sample;
  assign dsp_b      = s_coef;
  assign dsp_cea    = acc;
  assign dsp_ceb    = acc;
  // OPMODE is loaded on the same edge as M, so the post-adder always pairs
  // a product with the OPMODE of its own tap.
  assign dsp_cem    = v_q[0];
  assign dsp_ceop   = v_q[0];
  assign dsp_cep    = v_q[1];
  assign dsp_opmode = f_q[0] ? OPM_FIRST : OPM_ACC;

  dsp_mac_vpipe u_vpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dsp_rst),
    .in_valid (acc),
    .in_first (beat_first),
    .in_last  (beat_last),
    .valid_q  (v_q),
    .first_q  (f_q),
    .last_q   (l_q)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          tap_cnt_d  = TAP_W'(1);
          beat_first = 1'b1;
          beat_last  = (N_TAPS == 1);
          state_d    = (N_TAPS == 1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (acc) begin
          tap_cnt_d = tap_cnt_q + 1'b1;
          if (tap_cnt_q == LAST_IDX) begin
            beat_last = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (res_cap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  // A capture on the same edge as a downstream accept wins, keeping the
  // output valid with the new sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (res_cap) begin
      m_valid <= 1'b1;
      m_data  <= dsp_p;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_jobs  <= '0;
    end else begin
      if ((state_q == RUN) && !s_valid) perf_stall <= perf_stall + 32'd1;
      if (res_cap)                      perf_jobs  <= perf_jobs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
// Two sequencers (N_TAPS=4 and N_TAPS=1), each driving a behavioural DSP48A1
// with A1/B1, M, OPMODE and P registered and synchronous resets. Expected
// results are queued when the last tap is accepted; a monitor pops and
// compares data and latency whenever a new result is presented.
// -----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

  typedef struct {
    logic [47:0] data;
    longint      due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: N_TAPS=4 instance, index 1: N_TAPS=1 instance
  logic        s_valid_w [2];
  logic        s_ready_w [2];
  logic [17:0] s_sample_w[2];
  logic [17:0] s_coef_w  [2];
  logic        m_valid_w [2];
  logic        m_ready_w [2];
  logic [47:0] m_data_w  [2];
  logic        busy_w    [2];
  logic [17:0] a_w       [2];
  logic [17:0] b_w       [2];
  logic [7:0]  opm_w     [2];
  logic        cea_w[2], ceb_w[2], ceop_w[2], cem_w[2], cep_w[2], drst_w[2];
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_stall_w[2];
  logic [31:0] perf_jobs_w [2];
`endif

  // Slice model state
  logic [17:0] a1_r[2] = '{default: '0};
  logic [17:0] b1_r[2] = '{default: '0};
  logic [35:0] m_r [2] = '{default: '0};
  logic [7:0]  op_r[2] = '{default: '0};
  logic [47:0] p_r [2] = '{default: '0};

  dsp_mac_sequencer #(.N_TAPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid_w[0]), .s_ready(s_ready_w[0]),
    .s_sample(s_sample_w[0]), .s_coef(s_coef_w[0]),
    .m_valid(m_valid_w[0]), .m_ready(m_ready_w[0]), .m_data(m_data_w[0]),
    .busy(busy_w[0]), .dsp_a(a_w[0]), .dsp_b(b_w[0]), .dsp_opmode(opm_w[0]),
    .dsp_cea(cea_w[0]), .dsp_ceb(ceb_w[0]), .dsp_ceop(ceop_w[0]),
    .dsp_cem(cem_w[0]), .dsp_cep(cep_w[0]), .dsp_rst(drst_w[0]),
`ifdef MAC_SEQ_PERF_EN
    .perf_stall(perf_stall_w[0]), .perf_jobs(perf_jobs_w[0]),
`endif
    .dsp_p(p_r[0])
  );

  dsp_mac_sequencer #(.N_TAPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid_w[1]), .s_ready(s_ready_w[1]),
    .s_sample(s_sample_w[1]), .s_coef(s_coef_w[1]),
    .m_valid(m_valid_w[1]), .m_ready(m_ready_w[1]), .m_data(m_data_w[1]),
    .busy(busy_w[1]), .dsp_a(a_w[1]), .dsp_b(b_w[1]), .dsp_opmode(opm_w[1]),
    .dsp_cea(cea_w[1]), .dsp_ceb(ceb_w[1]), .dsp_ceop(ceop_w[1]),
    .dsp_cem(cem_w[1]), .dsp_cep(cep_w[1]), .dsp_rst(drst_w[1]),
`ifdef MAC_SEQ_PERF_EN
    .perf_stall(perf_stall_w[1]), .perf_jobs(perf_jobs_w[1]),
`endif
    .dsp_p(p_r[1])
  );

  // Post-adder: X from OPMODE[1:0] (01 -> M), Z from OPMODE[3:2] (10 -> P),
  // CIN = OPMODE[5], OPMODE[7] selects subtract. C/D/PCIN are tied to 0.
  function automatic logic [47:0] post_add(input logic [7:0] op,
                                           input logic [35:0] m,
                                           input logic [47:0] p);
    logic [47:0] x, z, cin;
    x   = (op[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    z   = (op[3:2] == 2'b10) ? p : 48'd0;
    cin = {47'd0, op[5]};
    return op[7] ? (z - (x + cin)) : (z + x + cin);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (drst_w[k]) begin
        a1_r[k] <= '0; b1_r[k] <= '0; m_r[k] <= '0; op_r[k] <= '0; p_r[k] <= '0;
      end else begin
        if (cea_w[k])  a1_r[k] <= a_w[k];
        if (ceb_w[k])  b1_r[k] <= b_w[k];
        if (cem_w[k])  m_r[k]  <= a1_r[k] * b1_r[k];
        if (ceop_w[k]) op_r[k] <= opm_w[k];
        if (cep_w[k])  p_r[k]  <= post_add(op_r[k], m_r[k], p_r[k]);
      end
    end
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   n_cea = 0, n_ceb = 0, n_ceop = 0, n_cem = 0, n_cep = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [47:0] data, input longint due);
    exp_t e;
    e.data = data;
    e.due  = due;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: a new result is presented when m_valid is high and the previous
  // cycle either had no valid or completed a handshake.
  logic [47:0] held_exp[2] = '{default: '0};
  bit          prev_v [2]  = '{default: 1'b0};
  bit          prev_hs[2]  = '{default: 1'b0};

  initial begin : monitor
    exp_t e;
    bit   got;
    forever begin
      @(negedge clk);
      #2;
      if (cea_w[0])  n_cea++;
      if (ceb_w[0])  n_ceb++;
      if (ceop_w[0]) n_ceop++;
      if (cem_w[0])  n_cem++;
      if (cep_w[0])  n_cep++;
      for (int k = 0; k < 2; k++) begin
        if (m_valid_w[k] && (!prev_v[k] || prev_hs[k])) begin
          got = 1'b0;
          if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          if (!got) begin
            total++;
            bad++;
            $display("FAIL unexpected_result dut%0d: actual m_data=%0d required no result", k, m_data_w[k]);
          end else begin
            check($sformatf("result_data_dut%0d", k), 64'(m_data_w[k]), 64'(e.data));
            check($sformatf("result_latency_dut%0d", k), cyc, e.due);
            held_exp[k] = e.data;
          end
        end else if (m_valid_w[k]) begin
          check($sformatf("result_hold_dut%0d", k), 64'(m_data_w[k]), 64'(held_exp[k]));
        end
        prev_v[k]  = m_valid_w[k];
        prev_hs[k] = m_valid_w[k] && m_ready_w[k];
      end
    end
  end

  // Drives one pair and returns the edge number on which it was accepted.
  task automatic send(input int k, input logic [17:0] a, input logic [17:0] b,
                      output longint acc_edge);
    int waited = 0;
    @(negedge clk);
    s_valid_w[k]  = 1'b1;
    s_sample_w[k] = a;
    s_coef_w[k]   = b;
    #1;
    while (!s_ready_w[k] && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!s_ready_w[k]) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d: actual s_ready=0 after %0d cycles required 1", k, waited);
    end
    acc_edge = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid_w[k] = 1'b0;
    end
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: actual pending=%0d required 0", q0.size() + q1.size());
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    longint      e;
    int          c_cea, c_ceb, c_ceop, c_cem, c_cep;
    logic [17:0] sa[4];
    logic [17:0] sb[4];
`ifdef MAC_SEQ_PERF_EN
    logic [31:0] ps0, pj0;
`endif
    sa = '{18'd1, 18'd2, 18'd3, 18'd4};
    sb = '{18'd10, 18'd20, 18'd30, 18'd40};
    for (int k = 0; k < 2; k++) begin
      s_valid_w[k] = 1'b0; s_sample_w[k] = '0; s_coef_w[k] = '0; m_ready_w[k] = 1'b1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid_w[0]), 64'd0);
    check("rst_m_data", 64'(m_data_w[0]), 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_dsp_rst", 64'(drst_w[0]), 64'd1);
    check("rst_m_valid_n1", 64'(m_valid_w[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("dsp_rst_held", 64'(drst_w[0]), 64'd1);
    @(negedge clk);
    #1;
    check("dsp_rst_dropped", 64'(drst_w[0]), 64'd0);
    check("idle_s_ready", 64'(s_ready_w[0]), 64'd1);

    // Back-to-back taps: 1*10 + 2*20 + 3*30 + 4*40 = 300
    for (int i = 0; i < 4; i++) begin
      send(0, sa[i], sb[i], e);
      if (i == 1) begin
        #1;
        check("busy_mid_job", 64'(busy_w[0]), 64'd1);
      end
    end
    push(0, 48'd300, e + 3);
    idle(0, 1);
    wait_empty(20);

    // Two-cycle gap between taps 2 and 3; every CE fires exactly 4 times
    c_cea = n_cea; c_ceb = n_ceb; c_ceop = n_ceop; c_cem = n_cem; c_cep = n_cep;
`ifdef MAC_SEQ_PERF_EN
    ps0 = perf_stall_w[0];
    pj0 = perf_jobs_w[0];
`endif
    send(0, sa[0], sb[0], e);
    send(0, sa[1], sb[1], e);
    idle(0, 2);
    send(0, sa[2], sb[2], e);
    send(0, sa[3], sb[3], e);
    push(0, 48'd300, e + 3);
    idle(0, 1);
    wait_empty(20);
    check("gap_cea_count", 64'(n_cea - c_cea), 64'd4);
    check("gap_ceb_count", 64'(n_ceb - c_ceb), 64'd4);
    check("gap_ceop_count", 64'(n_ceop - c_ceop), 64'd4);
    check("gap_cem_count", 64'(n_cem - c_cem), 64'd4);
    check("gap_cep_count", 64'(n_cep - c_cep), 64'd4);
`ifdef MAC_SEQ_PERF_EN
    check("perf_stall_gap", 64'(perf_stall_w[0] - ps0), 64'd2);
    check("perf_jobs_gap", 64'(perf_jobs_w[0] - pj0), 64'd1);
`endif

    // Result held with m_ready low; next job blocked, then starts on accept
    @(negedge clk);
    m_ready_w[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, sa[i], sb[i], e);
    push(0, 48'd300, e + 3);
    idle(0, 1);
    repeat (6) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      s_valid_w[0] = 1'b1; s_sample_w[0] = 18'd1; s_coef_w[0] = 18'd1;
      #1;
      check("idle_blocked_s_ready", 64'(s_ready_w[0]), 64'd0);
    end
    @(negedge clk);
    m_ready_w[0] = 1'b1;
    s_valid_w[0] = 1'b1; s_sample_w[0] = 18'd1; s_coef_w[0] = 18'd1;
    #1;
    check("same_cycle_start", 64'(s_ready_w[0]), 64'd1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) send(0, 18'd1, 18'd1, e);
    push(0, 48'd4, e + 3);
    idle(0, 1);
    wait_empty(20);

    // N_TAPS=1: (2^18-1)^2, then a small product to confirm Z=0 on tap 0
    send(1, 18'd262143, 18'd262143, e);
    push(1, 48'd68718952449, e + 3);
    idle(1, 1);
    wait_empty(20);
    send(1, 18'd3, 18'd5, e);
    push(1, 48'd15, e + 3);
    idle(1, 1);
    wait_empty(20);

    // Reset after tap 2: job abandoned, then a clean job
    send(0, sa[0], sb[0], e);
    send(0, sa[1], sb[1], e);
    @(negedge clk);
    s_valid_w[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_w[0]), 64'd0);
    check("midrst_m_valid", 64'(m_valid_w[0]), 64'd0);
    check("midrst_dsp_rst", 64'(drst_w[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_dsp_rst_held", 64'(drst_w[0]), 64'd1);
    @(negedge clk);
    #1;
    check("midrst_dsp_rst_dropped", 64'(drst_w[0]), 64'd0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) send(0, 18'd1, 18'd1, e);
    push(0, 48'd4, e + 3);
    idle(0, 1);
    wait_empty(20);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
